// File: rtl/prep_pkg.sv
// Shared types and constants for the shape pre-processing sequencer.
// Latency: n/a (package only).
// Backpressure: n/a.
package prep_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_FETCH,
    ST_WAIT,
    ST_WRITE,
    ST_DONE
  } prep_state_t;

  // 800x600@60 timing: 1056 pixel clocks per line, 28 blanking lines.
  // A full pass must fit in the vertical blank between endframe and newframe.
  localparam int PREP_H_TOTAL       = 1056;
  localparam int PREP_VBLANK_LINES  = 28;
  localparam int PREP_VBLANK_CYCLES = PREP_H_TOTAL * PREP_VBLANK_LINES;

  // Largest datapath latency the sequencer is expected to wait out.
  localparam int PREP_LAT_MAX = 64;

  // Slot id width; never narrower than one bit.
  function automatic int prep_idw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/prep_latency_counter.sv
// Purpose: down-counter that times the external trig/rotate datapath latency.
// Latency: o_expire rises LAT-1 enabled cycles after i_load (LAT enabled cycles incl. the expiring one).
// Backpressure: none; i_en simply holds the count.
// Ports: clk/rst (sync, active-high), i_load reloads LAT-1, i_en counts down,
//        o_expire is high when the count has reached zero.
module prep_latency_counter #(
  parameter int LAT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_en,
  output logic o_expire
);

  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(LAT - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= LOAD_VAL;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_expire = (r_cnt == '0);

endmodule

// File: rtl/shape_prep_sequencer.sv
// Purpose: per-frame walk of the shape table; feeds each pending slot's angle/origin
//          to the external cos/sin/rotate datapath and writes sin/cos/ix/iy back.
// Latency: LAT+3 cycles per processed slot, 1 per skipped slot, +1 for DONE.
// Backpressure: none; a start while busy is dropped and flagged on the sticky overrun.
// Ports: clk/rst (sync, active-high); start/full begin a pass; dirty_set marks edited
//        slots; rd_* combinational slot fetch; calc_* datapath operands/results;
//        wr_* registered write-back; busy/done/overrun status.
module shape_prep_sequencer
  import prep_pkg::*;
#(
  parameter int MAXSHP = 16,
  parameter int INTW   = 16,
  parameter int FLTW   = 32,
  parameter int FRACW  = 16,
  parameter int LAT    = 4,
  parameter int IDW    = prep_idw(MAXSHP)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              full,
  input  logic [MAXSHP-1:0] dirty_set,
  output logic [IDW-1:0]    rd_id,
  input  logic [INTW-1:0]   rd_angle,
  input  logic [INTW-1:0]   rd_x,
  input  logic [INTW-1:0]   rd_y,
  output logic [INTW-1:0]   calc_angle,
  output logic [FLTW-1:0]   calc_x0,
  output logic [FLTW-1:0]   calc_y0,
  input  logic [FLTW-1:0]   calc_sin,
  input  logic [FLTW-1:0]   calc_cos,
  input  logic [FLTW-1:0]   calc_ix,
  input  logic [FLTW-1:0]   calc_iy,
  output logic              wr_en,
  output logic [IDW-1:0]    wr_id,
  output logic [FLTW-1:0]   wr_sin,
  output logic [FLTW-1:0]   wr_cos,
  output logic [FLTW-1:0]   wr_ix,
  output logic [FLTW-1:0]   wr_iy,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  // Elaboration-time sanity checks
  if (MAXSHP < 2) begin : g_chk_maxshp
    $error("shape_prep_sequencer: MAXSHP must be >= 2");
  end
  if ((LAT < 1) || (LAT > PREP_LAT_MAX)) begin : g_chk_lat
    $error("shape_prep_sequencer: LAT out of range");
  end
  if (MAXSHP * (LAT + 3) + 1 > PREP_VBLANK_CYCLES) begin : g_chk_vblank
    $error("shape_prep_sequencer: full pass does not fit in the vertical blank");
  end
  if (FLTW < INTW + FRACW) begin : g_chk_fltw
    $error("shape_prep_sequencer: FLTW too narrow for {x, FRACW zeros}");
  end

  prep_state_t       r_state;
  prep_state_t       w_state_nxt;
  logic [IDW-1:0]    r_rd_id;
  logic [MAXSHP-1:0] r_pending;
  logic [MAXSHP-1:0] r_dirty;
  logic [INTW-1:0]   r_calc_angle;
  logic [FLTW-1:0]   r_calc_x0;
  logic [FLTW-1:0]   r_calc_y0;
  logic              r_wr_en;
  logic [IDW-1:0]    r_wr_id;
  logic [FLTW-1:0]   r_wr_sin;
  logic [FLTW-1:0]   r_wr_cos;
  logic [FLTW-1:0]   r_wr_ix;
  logic [FLTW-1:0]   r_wr_iy;
  logic              r_busy;
  logic              r_overrun;

  logic w_accept;   // start taken in IDLE
  logic w_fetch;    // latch datapath operands
  logic w_capture;  // latch datapath results, issue write next cycle
  logic w_rd_inc;   // advance to the next slot
  logic w_last;
  logic w_expire;

  assign w_last = (r_rd_id == IDW'(MAXSHP - 1));

  prep_latency_counter #(
    .LAT (LAT)
  ) u_lat_cnt (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_fetch),
    .i_en     (r_state == ST_WAIT),
    .o_expire (w_expire)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_fetch     = 1'b0;
    w_capture   = 1'b0;
    w_rd_inc    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (r_pending[r_rd_id]) begin
          w_state_nxt = ST_FETCH;
        end else if (w_last) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_rd_inc = 1'b1;
        end
      end
      ST_FETCH: begin
        w_fetch     = 1'b1;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (w_expire) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (w_last) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_rd_inc    = 1'b1;
          w_state_nxt = ST_SCAN;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_rd_id      <= '0;
      r_pending    <= '0;
      r_dirty      <= '1;  // first pass after reset recomputes every slot
      r_calc_angle <= '0;
      r_calc_x0    <= '0;
      r_calc_y0    <= '0;
      r_wr_en      <= 1'b0;
      r_wr_id      <= '0;
      r_wr_sin     <= '0;
      r_wr_cos     <= '0;
      r_wr_ix      <= '0;
      r_wr_iy      <= '0;
      r_busy       <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_wr_en <= w_capture;

      // Edits in the start cycle are both consumed now and kept for next pass;
      // edits at any other time accumulate, even for slots already written.
      r_dirty <= w_accept ? dirty_set : (r_dirty | dirty_set);

      if (start && (r_state != ST_IDLE)) begin
        r_overrun <= 1'b1;
      end

      if (w_accept) begin
        r_pending <= full ? '1 : (r_dirty | dirty_set);
        r_rd_id   <= '0;
        r_busy    <= 1'b1;
      end

      if (w_rd_inc) begin
        r_rd_id <= r_rd_id + 1'b1;
      end

      if (w_fetch) begin
        r_calc_angle <= rd_angle;
        r_calc_x0    <= FLTW'(rd_x) << FRACW;
        r_calc_y0    <= FLTW'(rd_y) << FRACW;
      end

      if (w_capture) begin
        r_wr_id  <= r_rd_id;
        r_wr_sin <= calc_sin;
        r_wr_cos <= calc_cos;
        r_wr_ix  <= calc_ix;
        r_wr_iy  <= calc_iy;
      end

      if (r_state == ST_WRITE) begin
        r_pending[r_rd_id] <= 1'b0;
      end

      if (r_state == ST_DONE) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign rd_id      = r_rd_id;
  assign calc_angle = r_calc_angle;
  assign calc_x0    = r_calc_x0;
  assign calc_y0    = r_calc_y0;
  assign wr_en      = r_wr_en;
  assign wr_id      = r_wr_id;
  assign wr_sin     = r_wr_sin;
  assign wr_cos     = r_wr_cos;
  assign wr_ix      = r_wr_ix;
  assign wr_iy      = r_wr_iy;
  assign busy       = r_busy;
  assign done       = (r_state == ST_DONE);
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_shape_prep_sequencer.sv
// Bench for shape_prep_sequencer: MAXSHP=4, LAT=2, randomized slot data and passes.
// Latency: n/a.
// Backpressure: n/a.
module tb_shape_prep_sequencer;

  localparam int MAXSHP = 4;
  localparam int INTW   = 16;
  localparam int FRACW  = 16;
  localparam int FLTW   = 32;
  localparam int LAT    = 2;
  localparam int IDW    = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              full = 1'b0;
  logic [MAXSHP-1:0] dirty_set = '0;
  logic [IDW-1:0]    rd_id;
  logic [INTW-1:0]   rd_angle, rd_x, rd_y;
  logic [INTW-1:0]   calc_angle;
  logic [FLTW-1:0]   calc_x0, calc_y0;
  logic [FLTW-1:0]   calc_sin, calc_cos, calc_ix, calc_iy;
  logic              wr_en;
  logic [IDW-1:0]    wr_id;
  logic [FLTW-1:0]   wr_sin, wr_cos, wr_ix, wr_iy;
  logic              busy, done, overrun;

  logic [INTW-1:0] mem_ang [MAXSHP];
  logic [INTW-1:0] mem_x   [MAXSHP];
  logic [INTW-1:0] mem_y   [MAXSHP];

  always #5 clk = ~clk;

  // Core's shape arrays: combinational read
  assign rd_angle = mem_ang[rd_id];
  assign rd_x     = mem_x[rd_id];
  assign rd_y     = mem_y[rd_id];

  shape_prep_sequencer #(
    .MAXSHP (MAXSHP),
    .INTW   (INTW),
    .FLTW   (FLTW),
    .FRACW  (FRACW),
    .LAT    (LAT),
    .IDW    (IDW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .full       (full),
    .dirty_set  (dirty_set),
    .rd_id      (rd_id),
    .rd_angle   (rd_angle),
    .rd_x       (rd_x),
    .rd_y       (rd_y),
    .calc_angle (calc_angle),
    .calc_x0    (calc_x0),
    .calc_y0    (calc_y0),
    .calc_sin   (calc_sin),
    .calc_cos   (calc_cos),
    .calc_ix    (calc_ix),
    .calc_iy    (calc_iy),
    .wr_en      (wr_en),
    .wr_id      (wr_id),
    .wr_sin     (wr_sin),
    .wr_cos     (wr_cos),
    .wr_ix      (wr_ix),
    .wr_iy      (wr_iy),
    .busy       (busy),
    .done       (done),
    .overrun    (overrun)
  );

  // Stand-in datapath functions (arbitrary but distinct per operand)
  function automatic logic [31:0] f_sin(input logic [15:0] a);
    return {{16{a[15]}}, a} * 32'd3 + 32'd7;
  endfunction
  function automatic logic [31:0] f_cos(input logic [15:0] a);
    return {{16{a[15]}}, a} ^ 32'h1234_5678;
  endfunction
  function automatic logic [31:0] f_ix(input logic [31:0] x0, input logic [31:0] y0);
    return x0 + y0;
  endfunction
  function automatic logic [31:0] f_iy(input logic [31:0] x0, input logic [31:0] y0);
    return x0 - y0;
  endfunction

  // One register stage: results become valid on the LAT=2nd cycle after operands change
  logic [31:0] dp_sin, dp_cos, dp_ix, dp_iy;
  always @(posedge clk) begin
    dp_sin <= f_sin(calc_angle);
    dp_cos <= f_cos(calc_angle);
    dp_ix  <= f_ix(calc_x0, calc_y0);
    dp_iy  <= f_iy(calc_x0, calc_y0);
  end
  assign calc_sin = dp_sin;
  assign calc_cos = dp_cos;
  assign calc_ix  = dp_ix;
  assign calc_iy  = dp_iy;

  // Observed writes, one record per wr_en cycle
  typedef struct {
    int          cyc;
    logic [1:0]  id;
    logic [31:0] s, c, ix, iy, x0;
    logic [15:0] ang;
  } wrec_t;

  wrec_t wq[$];
  int cyc = 0;
  int done_total = 0;
  int done_last = 0;
  int busy_total = 0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (busy) busy_total <= busy_total + 1;
    if (done) begin
      done_total <= done_total + 1;
      done_last  <= cyc + 1;
    end
    if (wr_en) wq.push_back('{cyc + 1, wr_id, wr_sin, wr_cos, wr_ix, wr_iy, calc_x0, calc_angle});
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: slots awaiting recompute at the next non-full pass
  logic [MAXSHP-1:0] model_dirty;

  task automatic rand_mem();
    for (int i = 0; i < MAXSHP; i++) begin
      mem_ang[i] = 16'($urandom);
      mem_x[i]   = 16'($urandom);
      mem_y[i]   = 16'($urandom);
    end
  endtask

  task automatic pulse_dirty(input logic [MAXSHP-1:0] m);
    @(posedge clk); #1;
    dirty_set = m;
    model_dirty = model_dirty | m;
    @(posedge clk); #1;
    dirty_set = '0;
  endtask

  task automatic check_reset_outputs(input string nm);
    check_val({nm, ":busy"},    busy,       0);
    check_val({nm, ":done"},    done,       0);
    check_val({nm, ":wr_en"},   wr_en,      0);
    check_val({nm, ":overrun"}, overrun,    0);
    check_val({nm, ":rd_id"},   rd_id,      0);
    check_val({nm, ":c_ang"},   calc_angle, 0);
    check_val({nm, ":c_x0"},    calc_x0,    0);
    check_val({nm, ":c_y0"},    calc_y0,    0);
    check_val({nm, ":wr_id"},   wr_id,      0);
    check_val({nm, ":wr_sin"},  wr_sin,     0);
    check_val({nm, ":wr_cos"},  wr_cos,     0);
    check_val({nm, ":wr_ix"},   wr_ix,      0);
    check_val({nm, ":wr_iy"},   wr_iy,      0);
  endtask

  // Runs one pass and checks every write, its timing, the done cycle and busy length.
  // mid_k>0 pulses dirty_set[mid_slot] in cycle start+mid_k; dbl re-pulses start at start+3.
  task automatic do_pass(input string nm, input bit f, input logic [MAXSHP-1:0] ds0,
                         input int mid_k, input int mid_slot, input bit dbl);
    logic [MAXSHP-1:0] pend;
    logic [31:0] x0, y0;
    int s_cyc, base, d0, b0, t, nexp, k;
    pend = f ? '1 : (model_dirty | ds0);
    model_dirty = ds0;
    base = wq.size();
    d0 = done_total;
    @(posedge clk); #1;
    start = 1'b1;
    full = f;
    dirty_set = ds0;
    s_cyc = cyc + 1;
    b0 = busy_total;
    k = 1;
    while (done_total == d0 && k < 200) begin
      @(posedge clk); #1;
      start = dbl && (k == 3);
      dirty_set = (k == mid_k) ? MAXSHP'(1 << mid_slot) : '0;
      if (k == mid_k) model_dirty = model_dirty | MAXSHP'(1 << mid_slot);
      k++;
    end
    @(posedge clk); #1;
    start = 1'b0;
    dirty_set = '0;
    @(negedge clk); #1;
    check_val({nm, ":done_pulses"}, done_total - d0, 1);

    t = s_cyc;
    nexp = 0;
    for (int id = 0; id < MAXSHP; id++) begin
      if (pend[id]) begin
        t += LAT + 3;
        if (wq.size() > base + nexp) begin
          x0 = {mem_x[id], 16'h0};
          y0 = {mem_y[id], 16'h0};
          check_val($sformatf("%s:w%0d_id", nm, nexp),  wq[base+nexp].id,  id);
          check_val($sformatf("%s:w%0d_cyc", nm, nexp), wq[base+nexp].cyc - s_cyc, t - s_cyc);
          check_val($sformatf("%s:w%0d_ang", nm, nexp), wq[base+nexp].ang, mem_ang[id]);
          check_val($sformatf("%s:w%0d_x0", nm, nexp),  wq[base+nexp].x0,  x0);
          check_val($sformatf("%s:w%0d_sin", nm, nexp), wq[base+nexp].s,   f_sin(mem_ang[id]));
          check_val($sformatf("%s:w%0d_cos", nm, nexp), wq[base+nexp].c,   f_cos(mem_ang[id]));
          check_val($sformatf("%s:w%0d_ix", nm, nexp),  wq[base+nexp].ix,  f_ix(x0, y0));
          check_val($sformatf("%s:w%0d_iy", nm, nexp),  wq[base+nexp].iy,  f_iy(x0, y0));
        end
        nexp++;
      end else begin
        t += 1;
      end
    end
    check_val({nm, ":n_writes"},  wq.size() - base,   nexp);
    check_val({nm, ":done_cyc"},  done_last - s_cyc,  t + 1 - s_cyc);
    check_val({nm, ":busy_len"},  busy_total - b0,    t + 1 - s_cyc);
    check_val({nm, ":busy_end"},  busy,               0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1);
  end

  initial begin
    int base;
    rand_mem();
    model_dirty = '1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Dirty is all ones out of reset: every slot written
    do_pass("t1_after_reset", 1'b0, '0, 0, 0, 1'b0);

    // Single dirty slot with known values
    mem_ang[2] = 16'd90;
    mem_x[2]   = 16'd10;
    mem_y[2]   = 16'd20;
    pulse_dirty(4'b0100);
    do_pass("t2_slot2", 1'b0, '0, 0, 0, 1'b0);

    // Nothing dirty
    do_pass("t3_empty", 1'b0, '0, 0, 0, 1'b0);

    // Edit slot 0 while slot 1 is in WAIT; only the next pass picks it up
    rand_mem();
    do_pass("t4_full_mid", 1'b1, '0, 8, 0, 1'b0);
    do_pass("t4_next", 1'b0, '0, 0, 0, 1'b0);

    // Start while busy
    check_val("t5_overrun_pre", overrun, 0);
    do_pass("t5_dbl", 1'b1, '0, 0, 0, 1'b1);
    check_val("t5_overrun_set", overrun, 1);
    do_pass("t5_after", 1'b0, '0, 0, 0, 1'b0);
    check_val("t5_overrun_sticky", overrun, 1);

    // Edit in the start cycle is processed now and again next pass
    do_pass("t_start_edit", 1'b0, 4'b0010, 0, 0, 1'b0);
    do_pass("t_start_kept", 1'b0, '0, 0, 0, 1'b0);

    // Randomized passes
    for (int r = 0; r < 12; r++) begin
      rand_mem();
      if ($urandom_range(0, 2) == 0) pulse_dirty(MAXSHP'($urandom));
      do_pass($sformatf("rnd%0d", r), ($urandom_range(0, 3) == 0), MAXSHP'($urandom),
              $urandom_range(0, 4), $urandom_range(0, MAXSHP - 1), ($urandom_range(0, 3) == 0));
    end

    // Reset during slot 1 WAIT: pass abandoned, no further writes
    rand_mem();
    base = wq.size();
    @(posedge clk); #1;
    start = 1'b1;
    full = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    full = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;
    check_reset_outputs("t6_rst");
    repeat (20) @(negedge clk);
    #1;
    check_val("t6_writes", wq.size() - base, 1);
    if (wq.size() > base) check_val("t6_w0_id", wq[base].id, 0);
    model_dirty = '1;
    do_pass("t6_after", 1'b0, '0, 0, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
